// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix ALU and its storage controller.
package matrix_pkg;

    localparam int DATA_W  = 16;
    localparam int MAX_DIM = 5;
    localparam int SLOTS   = 4;
    localparam int DIM_W   = $clog2(MAX_DIM + 1);
    localparam int SLOT_W  = $clog2(SLOTS);

    typedef enum logic [1:0] {
        SLOT_A     = 2'd0,
        SLOT_B     = 2'd1,
        SLOT_C     = 2'd2,
        SLOT_SPARE = 2'd3
    } slot_id_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_DONE,
        S_CLEAR
    } mem_state_t;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_SCALE,
        OP_TRANSPOSE
    } alu_op_t;

    // A dimension is usable for a load when it lies in 1..max_dim.
    function automatic logic dim_legal(input int unsigned d, input int unsigned max_dim);
        return (d >= 1) && (d <= max_dim);
    endfunction

endpackage

// File: rtl/matrix_load_fsm.sv
// Load/clear sequencer: walks row/column counters and emits write strobes
// into the storage array owned by matrix_mem_ctrl.
module matrix_load_fsm #(
    parameter int MAX_DIM = matrix_pkg::MAX_DIM,
    parameter int SLOT_W  = matrix_pkg::SLOT_W,
    parameter int DIM_W   = matrix_pkg::DIM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic [SLOT_W-1:0] ld_slot,
    input  logic [DIM_W-1:0]  ld_m,
    input  logic [DIM_W-1:0]  ld_n,
    input  logic              ld_valid,
    input  logic              clr_start,
    input  logic [SLOT_W-1:0] clr_slot,
    output logic              elem_we,
    output logic              row_clr_we,
    output logic [SLOT_W-1:0] tgt_slot,
    output logic [DIM_W-1:0]  tgt_row,
    output logic [DIM_W-1:0]  tgt_col,
    output logic              dims_we,
    output logic [SLOT_W-1:0] dims_slot,
    output logic [DIM_W-1:0]  dims_m,
    output logic [DIM_W-1:0]  dims_n,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_error,
    output logic              clr_done,
    output logic              busy
);
    import matrix_pkg::*;

    localparam logic [DIM_W-1:0] LAST_ROW = DIM_W'(MAX_DIM - 1);
    localparam logic [DIM_W-1:0] ONE      = DIM_W'(1);

    mem_state_t        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  m_q, m_d;
    logic [DIM_W-1:0]  n_q, n_d;
    logic              ld_ready_d, ld_done_d, ld_error_d, clr_done_d, busy_d;

    assign tgt_slot = slot_q;
    assign tgt_row  = row_q;
    assign tgt_col  = col_q;

    // State, counters, latched request and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            slot_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            m_q      <= '0;
            n_q      <= '0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            ld_error <= 1'b0;
            clr_done <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            row_q    <= row_d;
            col_q    <= col_d;
            m_q      <= m_d;
            n_q      <= n_d;
            ld_ready <= ld_ready_d;
            ld_done  <= ld_done_d;
            ld_error <= ld_error_d;
            clr_done <= clr_done_d;
            busy     <= busy_d;
        end
    end

    // Next-state, counter stepping and storage write strobes.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        row_d      = row_q;
        col_d      = col_q;
        m_d        = m_q;
        n_d        = n_q;
        elem_we    = 1'b0;
        row_clr_we = 1'b0;
        dims_we    = 1'b0;
        dims_slot  = slot_q;
        dims_m     = '0;
        dims_n     = '0;
        ld_error_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d = S_CLEAR;
                    slot_d  = clr_slot;
                    row_d   = '0;
                end else if (ld_start) begin
                    if (dim_legal(32'(ld_m), MAX_DIM) && dim_legal(32'(ld_n), MAX_DIM)) begin
                        state_d   = S_LOAD;
                        slot_d    = ld_slot;
                        m_d       = ld_m;
                        n_d       = ld_n;
                        row_d     = '0;
                        col_d     = '0;
                        // Slot reads as empty while its contents are being replaced.
                        dims_we   = 1'b1;
                        dims_slot = ld_slot;
                    end else begin
                        ld_error_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (ld_valid) begin
                    elem_we = 1'b1;
                    if (col_q == n_q - ONE) begin
                        col_d = '0;
                        if (row_q == m_q - ONE) begin
                            state_d = S_LOAD_DONE;
                        end else begin
                            row_d = row_q + ONE;
                        end
                    end else begin
                        col_d = col_q + ONE;
                    end
                end
            end

            S_LOAD_DONE: begin
                dims_we = 1'b1;
                dims_m  = m_q;
                dims_n  = n_q;
                state_d = S_IDLE;
            end

            S_CLEAR: begin
                row_clr_we = 1'b1;
                if (row_q == '0) begin
                    dims_we = 1'b1;
                end
                if (row_q == LAST_ROW) begin
                    state_d = S_IDLE;
                end else begin
                    row_d = row_q + ONE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        ld_ready_d = (state_d == S_LOAD);
        ld_done_d  = (state_d == S_LOAD_DONE);
        busy_d     = (state_d != S_IDLE);
        clr_done_d = (state_d == S_CLEAR) && (row_d == LAST_ROW);
    end

endmodule

// File: rtl/matrix_mem_ctrl.sv
// Multi-slot matrix storage: combinational ALU reads, synchronous ALU writes,
// plus host row-major loads and slot clears sequenced by matrix_load_fsm.
module matrix_mem_ctrl #(
    parameter int DATA_W  = matrix_pkg::DATA_W,
    parameter int MAX_DIM = matrix_pkg::MAX_DIM,
    parameter int SLOTS   = matrix_pkg::SLOTS,
    localparam int SLOT_W = $clog2(SLOTS),
    localparam int DIM_W  = $clog2(MAX_DIM + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SLOT_W-1:0] rd_slot,
    input  logic [DIM_W-1:0]  rd_row,
    input  logic [DIM_W-1:0]  rd_col,
    output logic [DATA_W-1:0] rd_data,
    output logic [DIM_W-1:0]  cur_m,
    output logic [DIM_W-1:0]  cur_n,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [DIM_W-1:0]  wr_row,
    input  logic [DIM_W-1:0]  wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_we,
    input  logic [DIM_W-1:0]  res_m,
    input  logic [DIM_W-1:0]  res_n,
    input  logic              dim_we,
    input  logic              ld_start,
    input  logic [SLOT_W-1:0] ld_slot,
    input  logic [DIM_W-1:0]  ld_m,
    input  logic [DIM_W-1:0]  ld_n,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_error,
    input  logic              clr_start,
    input  logic [SLOT_W-1:0] clr_slot,
    output logic              clr_done,
    output logic              busy
);
    import matrix_pkg::*;

    localparam logic [DIM_W-1:0] DIM_LIMIT = DIM_W'(MAX_DIM);

    logic [DATA_W-1:0] mem   [SLOTS][MAX_DIM][MAX_DIM];
    logic [DIM_W-1:0]  dim_m [SLOTS];
    logic [DIM_W-1:0]  dim_n [SLOTS];

    logic              fsm_elem_we;
    logic              fsm_row_clr_we;
    logic [SLOT_W-1:0] fsm_slot;
    logic [DIM_W-1:0]  fsm_row;
    logic [DIM_W-1:0]  fsm_col;
    logic              fsm_dims_we;
    logic [SLOT_W-1:0] fsm_dims_slot;
    logic [DIM_W-1:0]  fsm_dims_m;
    logic [DIM_W-1:0]  fsm_dims_n;

    matrix_load_fsm #(
        .MAX_DIM (MAX_DIM),
        .SLOT_W  (SLOT_W),
        .DIM_W   (DIM_W)
    ) u_load_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_start   (ld_start),
        .ld_slot    (ld_slot),
        .ld_m       (ld_m),
        .ld_n       (ld_n),
        .ld_valid   (ld_valid),
        .clr_start  (clr_start),
        .clr_slot   (clr_slot),
        .elem_we    (fsm_elem_we),
        .row_clr_we (fsm_row_clr_we),
        .tgt_slot   (fsm_slot),
        .tgt_row    (fsm_row),
        .tgt_col    (fsm_col),
        .dims_we    (fsm_dims_we),
        .dims_slot  (fsm_dims_slot),
        .dims_m     (fsm_dims_m),
        .dims_n     (fsm_dims_n),
        .ld_ready   (ld_ready),
        .ld_done    (ld_done),
        .ld_error   (ld_error),
        .clr_done   (clr_done),
        .busy       (busy)
    );

    // Combinational read: cells outside the slot's current dims read as zero.
    always_comb begin
        rd_data = '0;
        cur_m   = dim_m[rd_slot];
        cur_n   = dim_n[rd_slot];
        if ((rd_row < cur_m) && (rd_col < cur_n) &&
            (rd_row < DIM_LIMIT) && (rd_col < DIM_LIMIT)) begin
            rd_data = mem[rd_slot][rd_row][rd_col];
        end
    end

    // Element storage: ALU write has priority over a load beat or row clear
    // landing on the same cell; writes to different cells all take effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SLOTS; s++) begin
                for (int unsigned r = 0; r < MAX_DIM; r++) begin
                    for (int unsigned c = 0; c < MAX_DIM; c++) begin
                        mem[s][r][c] <= '0;
                    end
                end
            end
        end else begin
            for (int unsigned s = 0; s < SLOTS; s++) begin
                for (int unsigned r = 0; r < MAX_DIM; r++) begin
                    for (int unsigned c = 0; c < MAX_DIM; c++) begin
                        if (wr_we && (wr_slot == SLOT_W'(s)) &&
                            (wr_row == DIM_W'(r)) && (wr_col == DIM_W'(c))) begin
                            mem[s][r][c] <= wr_data;
                        end else if (fsm_elem_we && (fsm_slot == SLOT_W'(s)) &&
                                     (fsm_row == DIM_W'(r)) && (fsm_col == DIM_W'(c))) begin
                            mem[s][r][c] <= ld_data;
                        end else if (fsm_row_clr_we && (fsm_slot == SLOT_W'(s)) &&
                                     (fsm_row == DIM_W'(r))) begin
                            mem[s][r][c] <= '0;
                        end
                    end
                end
            end
        end
    end

    // Per-slot dims: the sequencer's update wins so a completed load always
    // publishes the dims it latched at the start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SLOTS; s++) begin
                dim_m[s] <= '0;
                dim_n[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < SLOTS; s++) begin
                if (fsm_dims_we && (fsm_dims_slot == SLOT_W'(s))) begin
                    dim_m[s] <= fsm_dims_m;
                    dim_n[s] <= fsm_dims_n;
                end else if (dim_we && (wr_slot == SLOT_W'(s))) begin
                    dim_m[s] <= res_m;
                    dim_n[s] <= res_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_mem_ctrl.sv
// Self-checking bench for matrix_mem_ctrl: directed vectors, hand-built
// multi-cycle sequences and randomized traffic against a slot/array model.
module tb_matrix_mem_ctrl;

    localparam int DW = 16;
    localparam int MD = 5;
    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rd_slot;
    logic [2:0]  rd_row, rd_col;
    logic [15:0] rd_data;
    logic [2:0]  cur_m, cur_n;
    logic [1:0]  wr_slot;
    logic [2:0]  wr_row, wr_col;
    logic [15:0] wr_data;
    logic        wr_we;
    logic [2:0]  res_m, res_n;
    logic        dim_we;
    logic        ld_start;
    logic [1:0]  ld_slot;
    logic [2:0]  ld_m, ld_n;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready, ld_done, ld_error;
    logic        clr_start;
    logic [1:0]  clr_slot;
    logic        clr_done, busy;

    always #5 clk = ~clk;

    matrix_mem_ctrl #(
        .DATA_W  (DW),
        .MAX_DIM (MD),
        .SLOTS   (NS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_slot   (rd_slot),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_data   (rd_data),
        .cur_m     (cur_m),
        .cur_n     (cur_n),
        .wr_slot   (wr_slot),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .wr_we     (wr_we),
        .res_m     (res_m),
        .res_n     (res_n),
        .dim_we    (dim_we),
        .ld_start  (ld_start),
        .ld_slot   (ld_slot),
        .ld_m      (ld_m),
        .ld_n      (ld_n),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .ld_error  (ld_error),
        .clr_start (clr_start),
        .clr_slot  (clr_slot),
        .clr_done  (clr_done),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain per-slot arrays and dims.
    logic [15:0] ref_mem [NS][MD][MD];
    int          ref_m [NS];
    int          ref_n [NS];
    logic [15:0] ld_vals [MD*MD];

    typedef struct {
        logic [1:0]  slot;
        logic [2:0]  row;
        logic [2:0]  col;
        logic [15:0] exp_data;
        logic [2:0]  exp_m;
        logic [2:0]  exp_n;
    } rd_vec_t;

    rd_vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_read(input int s, input int r, input int c);
        if (r < ref_m[s] && c < ref_n[s]) return ref_mem[s][r][c];
        return 16'h0000;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            ref_m[s] = 0;
            ref_n[s] = 0;
            for (int r = 0; r < MD; r++)
                for (int c = 0; c < MD; c++)
                    ref_mem[s][r][c] = 16'h0000;
        end
    endtask

    task automatic idle_inputs();
        wr_we = 1'b0; dim_we = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; clr_start = 1'b0;
    endtask

    task automatic check_read(input int s, input int r, input int c, input string tag);
        @(negedge clk);
        rd_slot = 2'(s); rd_row = 3'(r); rd_col = 3'(c);
        #1;
        check({tag, " rd_data"}, 32'(rd_data), 32'(ref_read(s, r, c)));
        check({tag, " cur_m"}, 32'(cur_m), ref_m[s]);
        check({tag, " cur_n"}, 32'(cur_n), ref_n[s]);
    endtask

    task automatic alu_write(input int s, input int r, input int c, input logic [15:0] d,
                             input bit we, input bit dwe, input int m, input int n);
        wr_slot = 2'(s); wr_row = 3'(r); wr_col = 3'(c); wr_data = d; wr_we = we;
        res_m = 3'(m); res_n = 3'(n); dim_we = dwe;
        tick();
        wr_we = 1'b0; dim_we = 1'b0;
        if (we && r < MD && c < MD) ref_mem[s][r][c] = d;
        if (dwe) begin ref_m[s] = m; ref_n[s] = n; end
    endtask

    task automatic run_load(input int s, input int m, input int n,
                            input int stall_at, input int stall_len, input string tag);
        int cyc, k, stalled;
        bit acc, done;
        ld_start = 1'b1; ld_slot = 2'(s); ld_m = 3'(m); ld_n = 3'(n); ld_valid = 1'b0;
        k = 0; stalled = 0; done = 1'b0;
        tick();
        ld_start = 1'b0;
        cyc = 2;
        check({tag, " ld_ready on entry"}, 32'(ld_ready), 1);
        for (int i = 0; i < 200 && !done; i++) begin
            if (ld_done) begin
                done = 1'b1;
            end else begin
                if (k == stall_at && stalled < stall_len) begin
                    ld_valid = 1'b0;
                    stalled++;
                end else begin
                    ld_valid = (k < m * n);
                    ld_data  = (k < m * n) ? ld_vals[k] : 16'h0000;
                end
                acc = ld_ready && ld_valid;
                tick();
                if (acc) k++;
                cyc++;
            end
        end
        ld_valid = 1'b0;
        check({tag, " ld_done seen"}, 32'(done), 1);
        check({tag, " cycles to ld_done"}, cyc, 2 + m * n + stall_len);
        check({tag, " beats accepted"}, k, m * n);
        check({tag, " ld_ready at done"}, 32'(ld_ready), 0);
        tick();
        check({tag, " ld_done one pulse"}, 32'(ld_done), 0);
        check({tag, " busy after done"}, 32'(busy), 0);
        for (int e = 0; e < m * n; e++) ref_mem[s][e / n][e % n] = ld_vals[e];
        ref_m[s] = m;
        ref_n[s] = n;
    endtask

    task automatic run_clear(input int s, input string tag);
        int nb, done_at;
        clr_start = 1'b1; clr_slot = 2'(s);
        tick();
        clr_start = 1'b0;
        nb = 0; done_at = -1;
        for (int i = 0; i < 20 && busy; i++) begin
            nb++;
            if (clr_done) done_at = nb;
            tick();
        end
        check({tag, " clear busy cycles"}, nb, MD);
        check({tag, " clr_done cycle"}, done_at, MD);
        ref_m[s] = 0; ref_n[s] = 0;
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++)
                ref_mem[s][r][c] = 16'h0000;
    endtask

    task automatic bad_load(input int s, input int m, input int n, input string tag);
        ld_start = 1'b1; ld_slot = 2'(s); ld_m = 3'(m); ld_n = 3'(n);
        tick();
        ld_start = 1'b0;
        check({tag, " ld_error pulse"}, 32'(ld_error), 1);
        check({tag, " busy stays low"}, 32'(busy), 0);
        check({tag, " ld_ready low"}, 32'(ld_ready), 0);
        tick();
        check({tag, " ld_error one pulse"}, 32'(ld_error), 0);
    endtask

    initial begin
        int nb;
        rst_n = 1'b0;
        rd_slot = '0; rd_row = '0; rd_col = '0;
        wr_slot = '0; wr_row = '0; wr_col = '0; wr_data = '0;
        res_m = '0; res_n = '0; ld_slot = '0; ld_m = '0; ld_n = '0; ld_data = '0;
        clr_slot = '0;
        idle_inputs();
        model_reset();
        repeat (3) tick();
        check("reset busy", 32'(busy), 0);
        check("reset ld_ready", 32'(ld_ready), 0);
        check("reset ld_done", 32'(ld_done), 0);
        check("reset ld_error", 32'(ld_error), 0);
        check("reset clr_done", 32'(clr_done), 0);
        rst_n = 1'b1;
        for (int s = 0; s < NS; s++) check_read(s, 0, 0, "reset");

        // 2x3 load of 1..6 into slot 0, then a table of reads.
        for (int e = 0; e < 6; e++) ld_vals[e] = 16'(e + 1);
        tick();
        run_load(0, 2, 3, 99, 0, "load2x3");
        vecs[0]  = '{2'd0, 3'd0, 3'd0, 16'd1, 3'd2, 3'd3};
        vecs[1]  = '{2'd0, 3'd0, 3'd1, 16'd2, 3'd2, 3'd3};
        vecs[2]  = '{2'd0, 3'd0, 3'd2, 16'd3, 3'd2, 3'd3};
        vecs[3]  = '{2'd0, 3'd1, 3'd0, 16'd4, 3'd2, 3'd3};
        vecs[4]  = '{2'd0, 3'd1, 3'd1, 16'd5, 3'd2, 3'd3};
        vecs[5]  = '{2'd0, 3'd1, 3'd2, 16'd6, 3'd2, 3'd3};
        vecs[6]  = '{2'd0, 3'd2, 3'd0, 16'd0, 3'd2, 3'd3};
        vecs[7]  = '{2'd0, 3'd0, 3'd3, 16'd0, 3'd2, 3'd3};
        vecs[8]  = '{2'd0, 3'd4, 3'd4, 16'd0, 3'd2, 3'd3};
        vecs[9]  = '{2'd0, 3'd7, 3'd7, 16'd0, 3'd2, 3'd3};
        vecs[10] = '{2'd1, 3'd0, 3'd0, 16'd0, 3'd0, 3'd0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rd_slot = vecs[i].slot; rd_row = vecs[i].row; rd_col = vecs[i].col;
            #1;
            check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d cur_m", i), 32'(cur_m), 32'(vecs[i].exp_m));
            check($sformatf("vec%0d cur_n", i), 32'(cur_n), 32'(vecs[i].exp_n));
        end

        // Illegal load requests leave the slot alone.
        tick();
        bad_load(0, 6, 2, "bad m=6");
        bad_load(0, 3, 0, "bad n=0");
        check_read(0, 1, 2, "after bad load");

        // ALU dims then element write; write visible only after the edge.
        tick();
        alu_write(2, 0, 0, 16'h0, 1'b0, 1'b1, 3, 3);
        wr_slot = 2'd2; wr_row = 3'd2; wr_col = 3'd2; wr_data = 16'hFFF9; wr_we = 1'b1;
        rd_slot = 2'd2; rd_row = 3'd2; rd_col = 3'd2;
        #1;
        check("write before edge", 32'(rd_data), 32'h0);
        tick();
        wr_we = 1'b0;
        check("write -7 after edge", 32'(rd_data), 32'hFFF9);
        ref_mem[2][2][2] = 16'hFFF9;
        check_read(2, 2, 2, "slot2 dims");
        alu_write(2, 5, 0, 16'h7777, 1'b1, 1'b0, 0, 0);
        check_read(2, 0, 0, "row>=MAX_DIM ignored");

        // Clear slot 0 (with a far cell populated), then expose all 25 cells.
        alu_write(0, 4, 4, 16'h0055, 1'b1, 1'b0, 0, 0);
        run_clear(0, "clear0");
        check_read(0, 0, 0, "cleared dims");
        alu_write(0, 0, 0, 16'h0, 1'b0, 1'b1, 5, 5);
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++)
                check_read(0, r, c, $sformatf("clear0 cell%0d%0d", r, c));

        // Clear and load together: clear wins, load dropped silently.
        tick();
        clr_start = 1'b1; clr_slot = 2'd1;
        ld_start = 1'b1; ld_slot = 2'd2; ld_m = 3'd2; ld_n = 3'd2;
        tick();
        clr_start = 1'b0; ld_start = 1'b0;
        check("collide ld_error", 32'(ld_error), 0);
        check("collide ld_ready", 32'(ld_ready), 0);
        check("collide busy", 32'(busy), 1);
        nb = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            if (ld_done) nb++;
            tick();
        end
        check("collide no ld_done", nb, 0);
        check("collide idle again", 32'(busy), 0);
        check_read(2, 2, 2, "collide slot2 kept");

        // Load stalled for four cycles mid-stream.
        for (int e = 0; e < 12; e++) ld_vals[e] = 16'h0100 + 16'(e);
        tick();
        run_load(1, 3, 4, 5, 4, "stall3x4");
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                check_read(1, r, c, $sformatf("stall cell%0d%0d", r, c));

        // Same-cell ALU write vs load beat; different-cell writes both land.
        tick();
        ld_start = 1'b1; ld_slot = 2'd3; ld_m = 3'd2; ld_n = 3'd2;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 16'h0005;
        wr_we = 1'b1; wr_slot = 2'd3; wr_row = 3'd0; wr_col = 3'd0; wr_data = 16'h1234;
        tick();
        ld_data = 16'h0006;
        wr_slot = 2'd2; wr_data = 16'h0BAD;
        tick();
        wr_we = 1'b0;
        ld_data = 16'h0007;
        tick();
        ld_data = 16'h0008;
        tick();
        ld_valid = 1'b0;
        check("coll ld_done", 32'(ld_done), 1);
        tick();
        ref_mem[3][0][0] = 16'h1234; ref_mem[3][0][1] = 16'h0006;
        ref_mem[3][1][0] = 16'h0007; ref_mem[3][1][1] = 16'h0008;
        ref_m[3] = 2; ref_n[3] = 2;
        ref_mem[2][0][0] = 16'h0BAD;
        for (int e = 0; e < 4; e++) check_read(3, e / 2, e % 2, $sformatf("coll cell%0d", e));
        check_read(2, 0, 0, "coll other slot");

        // Randomized traffic against the model.
        tick();
        for (int it = 0; it < 300; it++) begin
            int op, s, m, n;
            op = $urandom_range(0, 11);
            s  = $urandom_range(0, NS - 1);
            if (op <= 7) begin
                alu_write(s, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom),
                          1'($urandom), ($urandom_range(0, 3) == 0),
                          $urandom_range(0, MD), $urandom_range(0, MD));
            end else if (op <= 9) begin
                m = $urandom_range(1, MD);
                n = $urandom_range(1, MD);
                for (int e = 0; e < m * n; e++) ld_vals[e] = 16'($urandom);
                run_load(s, m, n, $urandom_range(0, m * n - 1), $urandom_range(0, 3),
                         $sformatf("rand load %0d", it));
            end else if (op == 10) begin
                if ($urandom_range(0, 1) == 0) bad_load(s, 0, $urandom_range(1, MD), "rand bad m");
                else bad_load(s, $urandom_range(1, MD), $urandom_range(6, 7), "rand bad n");
            end else begin
                run_clear(s, "rand clear");
            end
            check_read($urandom_range(0, NS - 1), $urandom_range(0, 7), $urandom_range(0, 7),
                       $sformatf("rand rd %0d", it));
            tick();
        end

        // Reset in the middle of a load.
        for (int e = 0; e < 9; e++) ld_vals[e] = 16'hA000 + 16'(e);
        ld_start = 1'b1; ld_slot = 2'd1; ld_m = 3'd3; ld_n = 3'd3;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = ld_vals[0];
        tick();
        ld_data = ld_vals[1];
        tick();
        check("midload ld_ready", 32'(ld_ready), 1);
        rst_n = 1'b0;
        #1;
        check("rst busy", 32'(busy), 0);
        check("rst ld_ready", 32'(ld_ready), 0);
        for (int s = 0; s < NS; s++) begin
            rd_slot = 2'(s);
            #1;
            check($sformatf("rst cur_m slot%0d", s), 32'(cur_m), 0);
            check($sformatf("rst cur_n slot%0d", s), 32'(cur_n), 0);
        end
        ld_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int s = 0; s < NS; s++) begin
            alu_write(s, 0, 0, 16'h0, 1'b0, 1'b1, 5, 5);
            for (int r = 0; r < MD; r++)
                for (int c = 0; c < MD; c++)
                    check_read(s, r, c, $sformatf("post-rst s%0d cell%0d%0d", s, r, c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matrix_mem_ctrl.md
# matrix_mem_ctrl

Multi-slot matrix storage that responds to the matrix ALU's read, write and dimension ports. It also accepts row-major matrix loads from the host/input path and slot-clear requests. Reads are combinational, so the ALU samples data and dimensions in the same cycle it drives the address. Writes, loads and clears are synchronous and sequenced by a small FSM.

## Interface
- `DATA_W`, 16, element width (two's complement)
- `MAX_DIM`, 5, maximum rows/columns per matrix; legal dims are 1..MAX_DIM
- `SLOTS`, 4, number of matrix slots (slot 0=A, 1=B, 2=C, 3=spare)
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `rd_slot`  in  2  ALU read slot
- `rd_row`, `rd_col`  in  3  ALU read coordinates
- `rd_data`  out  16  element at (rd_slot, rd_row, rd_col); combinational
- `cur_m`, `cur_n`  out  3  dims of `rd_slot`; combinational
- `wr_slot`  in  2  ALU write slot
- `wr_row`, `wr_col`  in  3  ALU write coordinates
- `wr_data`  in  16  ALU write data
- `wr_we`  in  1  ALU element write enable
- `res_m`, `res_n`  in  3  ALU result dims
- `dim_we`  in  1  writes `res_m`/`res_n` into the dims of `wr_slot`
- `ld_start`  in  1  host load request; single-cycle pulse
- `ld_slot`  in  2  load target slot
- `ld_m`, `ld_n`  in  3  load dims
- `ld_valid`  in  1  `ld_data` valid
- `ld_data`  in  16  element, row-major order
- `ld_ready`  out  1  element accepted on this edge if `ld_valid`
- `ld_done`  out  1  one-cycle pulse when the load completes
- `ld_error`  out  1  one-cycle pulse when a load request is rejected
- `clr_start`  in  1  clear request; single-cycle pulse
- `clr_slot`  in  2  slot to clear
- `clr_done`  out  1  one-cycle pulse when the clear completes
- `busy`  out  1  high in any FSM state other than S_IDLE

## Operation
- Storage: `SLOTS` × `MAX_DIM` × `MAX_DIM` registers, plus a dims pair (m, n) per slot.
- Reset: all elements and dims are 0. FSM goes to S_IDLE. Every registered output (`ld_ready`, `ld_done`, `ld_error`, `clr_done`, `busy`) is 0.
- Read:
  - `rd_data` is 0 if `rd_row >= m` or `rd_col >= n` for the slot.
  - Otherwise `rd_data` is the stored element.
  - `cur_m`/`cur_n` always return the stored dims.
- ALU write:
  - `wr_we` writes the element on the edge; ignored if `wr_row` or `wr_col >= MAX_DIM`.
  - `dim_we` writes the slot dims on the edge, with no legality check.
  - Element and dims writes may occur in the same cycle.
  - ALU writes are accepted in every FSM state.
- FSM states:
  - S_IDLE:
    - `clr_start` → S_CLEAR.
    - Otherwise `ld_start` with `ld_m`, `ld_n` in 1..MAX_DIM → S_LOAD. Latch slot and dims, reset row/col counters to 0, set that slot's dims to 0.
    - Otherwise `ld_start` with illegal dims → pulse `ld_error`, stay in S_IDLE.
  - S_LOAD:
    - `ld_ready` = 1.
    - On `ld_valid`, write `ld_data` at (r, c) and increment c. When c = n−1, c wraps to 0 and r increments.
    - Acceptance of element (m−1, n−1) → S_LOAD_DONE.
  - S_LOAD_DONE: write the latched dims into the slot, pulse `ld_done`, → S_IDLE.
  - S_CLEAR:
    - Entry cycle sets the slot dims to 0.
    - A row counter 0..MAX_DIM−1 zeroes one full row per cycle.
    - After the last row, pulse `clr_done` → S_IDLE.
- Priority and collisions:
  - If `clr_start` and `ld_start` arrive together in S_IDLE, the clear wins and the load is dropped with no error.
  - `ld_start`/`clr_start` while `busy` are ignored.
  - If the ALU and the FSM write the same cell in the same cycle, the ALU wins. Different cells are both written.
  - An ALU `dim_we` to the slot being loaded is overwritten at S_LOAD_DONE.
- Reset mid-load or mid-clear: immediate return to the reset state. Partial contents are lost.

## Timing
- Read latency 0: `rd_data`, `cur_m` and `cur_n` are combinational from the address and stored state.
- Write latency: visible on reads the cycle after the edge.
- Load of an m×n matrix: 1 (accept) + m·n accepted beats + 1 (S_LOAD_DONE) cycles minimum. `ld_done` is high in the cycle after the final beat's edge.
- Clear: `busy` stays high for exactly MAX_DIM cycles. `clr_done` is high in the last S_CLEAR cycle.
- `ld_valid` low during S_LOAD stalls the counters indefinitely.

## Structure
- Shared package `matrix_pkg`: DATA_W, MAX_DIM, SLOTS, slot ids (SLOT_A/B/C), FSM state enum.
- The same package also carries the ALU opcodes so ALU and memory share one source.
- One natural sub-module: `matrix_load_fsm`. It owns the load/clear sequencing and counters, and emits internal write strobes into the storage array held by `matrix_mem_ctrl`.

## Test plan
- Load 2×3 [1..6] into slot 0 with continuous `ld_valid` → `ld_done` 8 cycles after `ld_start`, `cur_m`=2, `cur_n`=3, `rd_data`(1,2)=6, `rd_data`(2,0)=0.
- `ld_start` with `ld_m`=6 → `ld_error` pulse, `busy` stays 0, slot dims unchanged.
- ALU `dim_we` with 3×3 on slot 2, then write −7 at (2,2) → read of slot 2 (2,2) returns 0xFFF9 one cycle later.
- Clear slot 0 after a load → `busy` for 5 cycles, then `cur_m`=0 and every read returns 0.
- Load stalled mid-stream (`ld_valid` low for 4 cycles) → elements still land in correct row-major positions; `rst_n` low mid-load → all dims 0 and `busy` 0 immediately.
- Same-cycle ALU write and load beat to the same cell (slot 3, (0,0)): ALU value 0x1234 vs load value 0x0005 → slot 3 (0,0) reads 0x1234.
